// File: rtl/ram_arbiter.sv
// Two-port arbiter (instruction fetch + data memory) in front of a single-port RAM.
// Round-robin on ties; loads take ACCESS/WAIT/RESP, stores finish in ACCESS.
module ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_sel,
  output logic              ram_ld,
  output logic              ram_str,
  output logic              ram_clr,
  input  logic [DATA_W-1:0] ram_dataOut,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req (and its address/data) until it sees gnt
  // high during a clock cycle, then drops req after the edge closing that cycle.
  // Loads answer with a one-cycle rvalid two cycles after the gnt cycle.
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state;
  logic                owner_dm;
  logic                last_dm;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic in_access;
  logic arb_now;
  logic if_elig;
  logic dm_elig;
  logic pick_dm;

  assign in_access = (state == ACCESS);
  assign arb_now   = (state == IDLE) || (state == RESP) || (in_access && lat_we);

  // The current owner still holds req during its gnt cycle, so mask it out.
  assign if_elig = if_req && !(in_access && !owner_dm);
  assign dm_elig = dm_req && !(in_access && owner_dm);
  assign pick_dm = dm_elig && (!if_elig || !last_dm);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      last_dm   <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (arb_now) begin
        if (if_elig || dm_elig) begin
          state     <= ACCESS;
          owner_dm  <= pick_dm;
          last_dm   <= pick_dm;
          lat_addr  <= pick_dm ? dm_addr : if_addr;
          lat_we    <= pick_dm && dm_we;
          lat_wdata <= pick_dm ? dm_wdata : '0;
        end else begin
          state <= IDLE;
        end
      end else if (in_access) begin
        state <= WAIT;
      end else if (state == WAIT) begin
        state <= RESP;
        if (owner_dm) dm_rdata <= ram_dataOut;
        else          if_rdata <= ram_dataOut;
      end
    end
  end

  assign if_gnt      = in_access && !owner_dm;
  assign dm_gnt      = in_access && owner_dm;
  assign if_rvalid   = (state == RESP) && !owner_dm;
  assign dm_rvalid   = (state == RESP) && owner_dm;
  assign ram_sel     = in_access;
  assign ram_ld      = in_access && !lat_we;
  assign ram_str     = in_access && lat_we;
  assign ram_address = in_access ? lat_addr : '0;
  assign ram_dataIn  = in_access ? lat_wdata : '0;
  assign ram_clr     = clr;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random two-requester traffic,
// checked against a reference memory and a latency/ordering scoreboard.
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk;
  logic          clr;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_dataIn;
  logic          ram_sel;
  logic          ram_ld;
  logic          ram_str;
  logic          ram_clr;
  logic [DW-1:0] ram_dataOut;
  logic          busy;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_sel(ram_sel), .ram_ld(ram_ld),
    .ram_str(ram_str), .ram_clr(ram_clr), .ram_dataOut(ram_dataOut),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] v;
    v = DW'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
    if (i == 10) v = 32'h1234_1234;
    return v;
  endfunction

  // ---------------- single-port RAM model ----------------
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  initial begin
    ram_dataOut = '0;
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_sel && ram_str) ram_mem[ram_address] <= ram_dataIn;
      if (ram_sel && ram_ld)  ram_dataOut <= ram_mem[ram_address];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  int            if_cyc_q[$];
  int            dm_cyc_q[$];
  bit            gnt_log[$];
  int            cyc = 0;
  int            if_gnt_cyc = 0;
  int            dm_gnt_cyc = 0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (clr) begin
        // An aborted transaction produces no response.
        if_exp_q.delete(); dm_exp_q.delete();
        if_cyc_q.delete(); dm_cyc_q.delete();
        check("clr_busy", busy, 0);
        check("clr_ram_clr", ram_clr, 1);
      end else begin
        check("gnt_excl", if_gnt & dm_gnt, 0);
        check("rvalid_excl", if_rvalid & dm_rvalid, 0);
        check("ram_sel", ram_sel, if_gnt | dm_gnt);
        check("ram_clr", ram_clr, 0);
        if (!(if_gnt || dm_gnt)) begin
          check("idle_ram_addr", ram_address, 0);
          check("idle_ram_din", ram_dataIn, 0);
          check("idle_ram_strobes", {ram_ld, ram_str}, 0);
        end
        if (if_gnt) begin
          gnt_log.push_back(1'b0);
          if_gnt_cyc = cyc;
          check("if_ram_addr", ram_address, if_addr);
          check("if_ram_ld_str", {ram_ld, ram_str}, 2'b10);
          if_exp_q.push_back(ref_mem[if_addr]);
          if_cyc_q.push_back(cyc + 2);
        end
        if (dm_gnt) begin
          gnt_log.push_back(1'b1);
          dm_gnt_cyc = cyc;
          check("dm_ram_addr", ram_address, dm_addr);
          check("dm_ram_ld_str", {ram_ld, ram_str}, dm_we ? 2'b01 : 2'b10);
          if (dm_we) begin
            check("dm_ram_din", ram_dataIn, dm_wdata);
            ref_mem[dm_addr] = dm_wdata;
          end else begin
            dm_exp_q.push_back(ref_mem[dm_addr]);
            dm_cyc_q.push_back(cyc + 2);
          end
        end
        if (if_rvalid) begin
          if (if_exp_q.size() == 0) check("if_rvalid_unexpected", if_rvalid, 0);
          else begin
            check("if_rdata", if_rdata, if_exp_q.pop_front());
            check("if_rvalid_cycle", cyc, if_cyc_q.pop_front());
          end
        end else if (if_cyc_q.size() > 0 && if_cyc_q[0] <= cyc) begin
          check("if_rvalid_missing", if_rvalid, 1);
          void'(if_exp_q.pop_front());
          void'(if_cyc_q.pop_front());
        end
        if (dm_rvalid) begin
          if (dm_exp_q.size() == 0) check("dm_rvalid_unexpected", dm_rvalid, 0);
          else begin
            check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
            check("dm_rvalid_cycle", cyc, dm_cyc_q.pop_front());
          end
        end else if (dm_cyc_q.size() > 0 && dm_cyc_q[0] <= cyc) begin
          check("dm_rvalid_missing", dm_rvalid, 1);
          void'(dm_exp_q.pop_front());
          void'(dm_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; return just after the edge closing the gnt cycle.
  task automatic fetch(input logic [AW-1:0] a, output int lat);
    if_req = 1'b1;
    if_addr = a;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!if_gnt && lat < 40);
    check("if_gnt_seen", if_gnt, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat);
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dm_gnt && lat < 40);
    check("dm_gnt_seen", dm_gnt, 1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  task automatic wait_rvalid(input bit is_dm, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(is_dm ? dm_rvalid : if_rvalid) && n < 20);
    check(is_dm ? "dm_rvalid_seen" : "if_rvalid_seen", is_dm ? dm_rvalid : if_rvalid, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    int rv_cnt;
    clr = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_gnts", {if_gnt, dm_gnt}, 0);
    check("rst_rvalids", {if_rvalid, dm_rvalid}, 0);
    check("rst_ram_strobes", {ram_sel, ram_ld, ram_str}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_ram_clr", ram_clr, 1);
    clr = 1'b0;
    @(posedge clk); #1;

    // Tie right after reset: IF first, then alternate.
    gnt_log.delete();
    fork
      begin fetch(12'h001, lat); fetch(12'h002, lat); end
      begin dm_access(1'b0, 12'h003, '0, lat); dm_access(1'b0, 12'h004, '0, lat); end
    join
    repeat (4) @(posedge clk);
    #1;
    check("tie_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check("tie_order", gnt_log[i], i % 2);

    // Single fetch from IDLE.
    fetch(12'h00A, lat);
    check("fetch_gnt_lat", lat, 2);
    wait_rvalid(1'b0, n);
    check("fetch_rvalid_lat", n, 2);
    check("fetch_rdata", if_rdata, 32'h1234_1234);

    // Store then load of the same word.
    dm_access(1'b1, 12'h014, 32'hDEAD_BEEF, lat);
    check("store_gnt_lat", lat, 2);
    dm_access(1'b0, 12'h014, '0, lat);
    wait_rvalid(1'b1, n);
    check("load_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("if_rdata_kept", if_rdata, 32'h1234_1234);

    // Store granted while a fetch becomes pending: back-to-back ACCESS.
    fork
      dm_access(1'b1, 12'h01E, 32'hCAFE_F00D, lat);
      begin @(posedge clk); #1; fetch(12'h01E, n); end
    join
    check("b2b_gap", if_gnt_cyc - dm_gnt_cyc, 1);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_if_rdata", if_rdata, 32'hCAFE_F00D);

    // Reset in the middle of a load.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h014;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_gnt && n < 40);
    check("abort_gnt_seen", dm_gnt, 1);
    @(posedge clk); #2;
    clr = 1'b1;
    dm_req = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_dm_rdata", dm_rdata, 0);
    check("abort_ram_clr", ram_clr, 1);
    check("abort_rvalid", dm_rvalid, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    check("abort_ram_clr_rel", ram_clr, 0);
    rv_cnt = 0;
    repeat (8) begin @(negedge clk); if (dm_rvalid) rv_cnt++; end
    check("abort_no_rvalid", rv_cnt, 0);
    check("abort_dm_rdata_after", dm_rdata, 0);
    @(posedge clk); #1;

    // Random concurrent traffic on a small address window.
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          int g;
          int l;
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          fetch(AW'($urandom_range(0, 15)), l);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          int g;
          int l;
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          dm_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, l);
        end
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("final_if_q_empty", if_exp_q.size(), 0);
    check("final_dm_q_empty", dm_exp_q.size(), 0);
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
